fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined processor. Owns the PC, issues requests to instruction memory with a ready handshake, and latches `instruction_d` plus PC+2 for the decode/control stage. Handles hazard stalls, branch/jump redirects from execute, multicycle memory waits (with stale-response discard), and stops fetching after a decoded `halt`.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, issues instruction-memory requests, and latches the fetched
// word plus PC+2 for decode. Handles hazard stalls, execute-stage redirects,
// multicycle memory waits (discarding the stale response after a redirect)
// and freezes after a decoded halt until reset.
//
// Memory handshake: imem_req_o is the request valid and imem_ready_i is the
// response strobe for the address on imem_addr_o. A transfer completes on any
// rising edge where imem_req_o && imem_ready_i. While imem_req_o is high and
// imem_ready_i is low, imem_addr_o is held stable and fetch_stall_o is high.
// imem_data_i is only looked at on a completing edge.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_d_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_data_i,
    input  logic        imem_ready_i,
    output logic [15:0] instruction_d,
    output logic [15:0] pc_plus2_d,
    output logic        valid_d,
    output logic        fetch_stall_o,
    output logic [1:0]  state_dbg
);

    // RUN: normal fetching. DRAIN: a request was abandoned by a redirect and
    // its response must be swallowed before the new target can be requested.
    // HALTED: fetch permanently stopped until reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] pc_q, pc_n;
    logic [15:0] stale_addr_q, stale_addr_n;
    logic [15:0] instr_q, instr_n;
    logic [15:0] pc_plus2_q, pc_plus2_n;
    logic        valid_q, valid_n;
    logic [15:0] pc_inc;

    // 16-bit modulo increment; 16'hFFFE wraps to 16'h0000.
    assign pc_inc = pc_q + 16'd2;

    // Request/address outputs depend only on state, so the address stays
    // stable across wait cycles.
    always_comb begin
        imem_req_o    = (state_q != ST_HALTED);
        imem_addr_o   = (state_q == ST_DRAIN) ? stale_addr_q : pc_q;
        fetch_stall_o = imem_req_o & ~imem_ready_i;
    end

    assign instruction_d = instr_q;
    assign pc_plus2_d    = pc_plus2_q;
    assign valid_d       = valid_q;
    assign state_dbg     = state_q;

    // Next-state and IF/ID update; priority in RUN is
    // redirect > stall > halt > ready/wait.
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        stale_addr_n = stale_addr_q;
        instr_n      = instr_q;
        pc_plus2_n   = pc_plus2_q;
        valid_n      = valid_q;

        case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    // Flush the wrong-path instruction. If the in-flight
                    // request has not completed, remember it so its late
                    // response can be discarded.
                    pc_n    = redirect_pc_i;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                    if (!imem_ready_i) begin
                        stale_addr_n = pc_q;
                        state_n      = ST_DRAIN;
                    end
                end else if (stall_i) begin
                    // Hold everything; a response arriving now is refetched.
                end else if (halt_d_i && valid_q) begin
                    state_n = ST_HALTED;
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                end else if (imem_ready_i) begin
                    instr_n    = imem_data_i;
                    pc_plus2_n = pc_inc;
                    valid_n    = 1'b1;
                    pc_n       = pc_inc;
                end else begin
                    // Memory wait: one bubble per wait cycle.
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                end
            end

            ST_DRAIN: begin
                // IF/ID already holds the bubble from the redirect edge.
                // Only a newer redirect target is accepted here.
                if (redirect_i) begin
                    pc_n = redirect_pc_i;
                end
                if (imem_ready_i) begin
                    state_n = ST_RUN;
                end
            end

            ST_HALTED: begin
                // Frozen until reset.
            end

            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            stale_addr_q <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_plus2_q   <= 16'h0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            stale_addr_q <= stale_addr_n;
            instr_q      <= instr_n;
            pc_plus2_q   <= pc_plus2_n;
            valid_q      <= valid_n;
        end
    end

endmodule
